// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 IF stage: PC, single-outstanding imem fetch, IF/ID register
// Optional FETCH_PERF_EN adds stall/flush performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        BrFlush,
    input  logic [31:0] BrTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_INST,
    output logic        IF_ID_Valid,
    output logic [4:0]  IF_ID_RS1,
    output logic [4:0]  IF_ID_RS2,
    output logic [6:0]  OP
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] hold_inst, hold_inst_nx;
    logic        kill, kill_nx;
    logic        advance, accept, live_rsp, avail, deliver;
    logic [31:0] avail_inst;

    assign advance    = PCWrite && IF_ID_Write;
    assign accept     = (state == S_REQ) && imem_ready;
    assign live_rsp   = (state == S_WAIT) && imem_rvalid && !kill;
    assign avail      = live_rsp || (state == S_HOLD);
    assign avail_inst = (state == S_HOLD) ? hold_inst : imem_rdata;
    assign deliver    = advance && avail && !BrFlush;

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

    assign IF_ID_RS1 = IF_ID_INST[19:15];
    assign IF_ID_RS2 = IF_ID_INST[24:20];
    assign OP        = IF_ID_INST[6:0];

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        kill_nx      = kill;
        hold_inst_nx = hold_inst;
        if (deliver)
            pc_nx = pc + 32'd4;
        if (BrFlush)
            pc_nx = BrTarget & ~32'd3;
        case (state)
            S_IDLE: state_nx = S_REQ;
            S_REQ: begin
                // A redirect accepted in the same cycle still owes a response; kill drops it.
                if (accept) begin
                    state_nx = S_WAIT;
                    kill_nx  = BrFlush;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    kill_nx = 1'b0;
                    if (live_rsp && !BrFlush && !advance) begin
                        state_nx     = S_HOLD;
                        hold_inst_nx = imem_rdata;
                    end else begin
                        state_nx = S_REQ;
                    end
                end else if (BrFlush) begin
                    kill_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (BrFlush || advance)
                    state_nx = S_REQ;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            hold_inst <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            kill      <= kill_nx;
            hold_inst <= hold_inst_nx;
        end
    end

    // Bubbles keep the old PC; only the instruction and valid bit are meaningful.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            IF_ID_PC    <= '0;
            IF_ID_INST  <= NOP_INST;
            IF_ID_Valid <= 1'b0;
        end else if (BrFlush) begin
            IF_ID_INST  <= NOP_INST;
            IF_ID_Valid <= 1'b0;
        end else if (deliver) begin
            IF_ID_PC    <= pc;
            IF_ID_INST  <= avail_inst;
            IF_ID_Valid <= 1'b1;
        end else if (IF_ID_Write && !avail) begin
            IF_ID_INST  <= NOP_INST;
            IF_ID_Valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (!IF_ID_Write)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (BrFlush)
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule
